prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter D, default 12, is the instruction-address width and matches the program counter width.
REQ-002 Parameter W, default 9, is the instruction word width.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle load request; honoured only in IDLE, RUN or ERR.
REQ-006 len  input  D  number of instruction words to load; sampled when start is honoured.
REQ-007 in_valid  input  1  the source presents a word on in_data.
REQ-008 in_data  input  W  instruction word or trailing checksum word.
REQ-009 in_ready  output  1  the loader accepts in_data this cycle.
REQ-010 wr_en  output  1  instruction memory write strobe.
REQ-011 wr_addr  output  D  instruction memory write address.
REQ-012 wr_data  output  W  instruction memory write data.
REQ-013 cpu_hold  output  1  holds the CPU in reset while high.
REQ-014 load_ok  output  1  the last load completed with a matching checksum.
REQ-015 load_err  output  1  the last load failed its checksum.
REQ-016 words_loaded  output  D  count of words written in the current or last load.

Function
REQ-017 States: IDLE, LOAD, CHECK, RUN, ERR; a state register holds the current state.
REQ-018 A transfer occurs only in a cycle where in_valid and in_ready are both high; in_ready is high only in LOAD and CHECK.
REQ-019 IDLE: honoured start -> latch len, clear count and checksum -> LOAD if len != 0, else CHECK.
REQ-020 LOAD: each transfer writes in_data at address count; checksum ^= in_data; count += 1; after transfer number len -> CHECK.
REQ-021 Writes are registered: wr_en, wr_addr and wr_data are valid exactly one cycle after the transfer; wr_en is high for exactly one cycle per word.
REQ-022 CHECK: one transfer is compared with the running 9-bit XOR checksum; equal -> RUN, otherwise -> ERR; the checksum word is never written to memory.
REQ-023 cpu_hold is high in IDLE, LOAD, CHECK and ERR, and low only in RUN.
REQ-024 On entering RUN, load_ok is set and load_err is cleared; on entering ERR, load_err is set and load_ok is cleared; both are cleared when a start is honoured.
REQ-025 In RUN or ERR, an honoured start begins a new load exactly as from IDLE, and cpu_hold rises the following cycle.
REQ-026 In LOAD or CHECK, start is ignored and len is not re-sampled.
REQ-027 in_valid low stalls LOAD or CHECK indefinitely without state change; in_data is ignored when no transfer occurs.
REQ-028 The maximum len is 2^D-1; addresses run 0..len-1 and never wrap.
REQ-029 words_loaded equals count and holds its value in RUN and ERR.

Reset
REQ-030 When reset is asserted, the block asynchronously enters IDLE with cpu_hold=1, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, load_ok=0, load_err=0, words_loaded=0, and the checksum cleared.
REQ-031 Reset asserted mid-LOAD aborts the load immediately, with no further wr_en pulse, including one pending from the last transfer.
REQ-032 After reset is released, the first honoured start behaves as from power-up.

Verification
REQ-033 Basic load: start with len=3; send 0x101, 0x0F0, 0x003, then checksum 0x1F2 -> writes to addresses 0, 1, 2 one cycle after each transfer; RUN; cpu_hold=0; load_ok=1; words_loaded=3.
REQ-034 Bad checksum: len=2; send 0x001, 0x002, then 0x000 -> two writes; ERR; load_err=1; cpu_hold stays 1.
REQ-035 Zero length: start with len=0, then checksum 0x000 -> no wr_en; RUN; load_ok=1; words_loaded=0.
REQ-036 Backpressure: in_valid toggles 1/0 every cycle during len=4 -> exactly 4 writes at addresses 0..3; no duplicate or missing writes.
REQ-037 Mid-load events: start asserted during LOAD is ignored and the load completes; an async reset after 2 of 5 words returns IDLE immediately with no further writes, words_loaded=0 and cpu_hold=1.
REQ-038 Reload: from RUN, start with len=1, send 0x1AA then 0x1AA -> cpu_hold rises the next cycle; load_ok clears, then sets again on re-entry to RUN.

Source files
------------

// File: rtl/prog_loader_if.sv
// Load-path bundle between an instruction source / CPU wrapper and the
// program loader: load request, word stream, memory write port and status.
interface prog_loader_if #(
    parameter int D = 12,
    parameter int W = 9
);
    logic         start;
    logic [D-1:0] len;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         cpu_hold;
    logic         load_ok;
    logic         load_err;
    logic [D-1:0] words_loaded;

    // Source / supervisor side: issues loads and streams words.
    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data,
        input  cpu_hold, load_ok, load_err, words_loaded
    );

    // Loader side.
    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data,
        output cpu_hold, load_ok, load_err, words_loaded
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams len instruction words into instruction memory,
// checks a trailing XOR checksum word, then releases the CPU (RUN) or
// keeps it held (ERR). Every output is a register updated with the FSM.
module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERR
    } state_t;

    state_t       state;
    logic [D-1:0] len_q;
    logic [D-1:0] count;
    logic [W-1:0] csum;
    logic         in_ready_q;
    logic         wr_en_q;
    logic [D-1:0] wr_addr_q;
    logic [W-1:0] wr_data_q;
    logic         cpu_hold_q;
    logic         load_ok_q;
    logic         load_err_q;
    logic         xfer;

    // A word moves only when the source offers it and we are accepting.
    assign xfer = bus.in_valid && in_ready_q;

    // Load sequencer: state, counters, checksum and all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            count      <= '0;
            csum       <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            // NOTE: strobe defaults low every cycle so each accepted word
            // yields exactly one write pulse, never a stuck-high wr_en.
            wr_en_q <= 1'b0;
            case (state)
                IDLE, RUN, ERR: begin
                    if (bus.start) begin
                        len_q      <= bus.len;
                        count      <= '0;
                        csum       <= '0;
                        load_ok_q  <= 1'b0;
                        load_err_q <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        in_ready_q <= 1'b1;
                        state      <= (bus.len != '0) ? LOAD : CHECK;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= count;
                        wr_data_q <= bus.in_data;
                        csum      <= csum ^ bus.in_data;
                        count     <= count + 1'b1;
                        // Last word: count has not yet been bumped this cycle.
                        if (count == len_q - 1'b1) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        if (bus.in_data == csum) begin
                            state      <= RUN;
                            cpu_hold_q <= 1'b0;
                            load_ok_q  <= 1'b1;
                            load_err_q <= 1'b0;
                        end else begin
                            state      <= ERR;
                            load_err_q <= 1'b1;
                            load_ok_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b0;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    // Drive the interface straight from the registers.
    assign bus.in_ready     = in_ready_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.load_ok      = load_ok_q;
    assign bus.load_err     = load_err_q;
    assign bus.words_loaded = count;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized
// loads compared against a word-list / XOR reference model.
module tb_prog_loader;

    localparam int D = 12;
    localparam int W = 9;

    typedef logic [W-1:0] word_q_t[$];
    typedef struct {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    wr_t  wr_log[$];

    prog_loader_if #(.D(D), .W(W)) bus ();

    prog_loader #(.D(D), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Write monitor: every wr_en cycle seen mid-cycle is one memory write.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) wr_log.push_back('{bus.wr_addr, bus.wr_data});
    end

    // Global watchdog.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the checksum is the XOR of all data words.
    function automatic logic [W-1:0] model_csum(input word_q_t w);
        logic [W-1:0] x = '0;
        foreach (w[i]) x ^= w[i];
        return x;
    endfunction

    // Pulse start for one cycle (called and returning at a negedge).
    task automatic do_start(input logic [D-1:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = D'($urandom);
    endtask

    // Offer one word until accepted; check the registered write appears the
    // cycle after the transfer. Optional idle cycle afterwards (backpressure).
    task automatic send(input logic [W-1:0] d, input logic exp_wr,
                        input logic [D-1:0] exp_addr, input logic bp);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        n_cmp++;
        if (exp_wr) begin
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== exp_addr || bus.wr_data !== d) begin
                n_bad++;
                $display("FAIL write_timing: wr_en=%b addr=%0d data=%h required 1 %0d %h",
                         bus.wr_en, bus.wr_addr, bus.wr_data, exp_addr, d);
            end
        end else if (bus.wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL csum_not_written: wr_en=%b required 0", bus.wr_en);
        end
        if (bp) begin
            @(negedge clk);
            n_cmp++;
            if (bus.wr_en !== 1'b0) begin
                n_bad++;
                $display("FAIL wr_pulse_width: wr_en=%b required 0", bus.wr_en);
            end
        end
    endtask

    // Full load scenario: start, words, checksum, then compare status and
    // the write log against the model.
    task automatic do_load(input string name, input word_q_t words,
                           input logic [W-1:0] cs, input logic bp);
        logic ok;
        ok = (cs == model_csum(words));
        wr_log.delete();
        do_start(D'(words.size()));
        n_cmp++;
        if (bus.cpu_hold !== 1'b1 || bus.load_ok !== 1'b0 || bus.load_err !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_after_start: hold=%b ok=%b err=%b rdy=%b required 1 0 0 1",
                     name, bus.cpu_hold, bus.load_ok, bus.load_err, bus.in_ready);
        end
        foreach (words[i]) send(words[i], 1'b1, D'(i), bp);
        send(cs, 1'b0, '0, bp);
        n_cmp++;
        if (bus.cpu_hold !== !ok || bus.load_ok !== ok || bus.load_err !== !ok ||
            bus.in_ready !== 1'b0 || bus.words_loaded !== D'(words.size())) begin
            n_bad++;
            $display("FAIL %s_status: hold=%b ok=%b err=%b rdy=%b cnt=%0d required %b %b %b 0 %0d",
                     name, bus.cpu_hold, bus.load_ok, bus.load_err, bus.in_ready,
                     bus.words_loaded, !ok, ok, !ok, words.size());
        end
        n_cmp++;
        if (wr_log.size() != words.size()) begin
            n_bad++;
            $display("FAIL %s_write_count: got %0d required %0d", name, wr_log.size(), words.size());
        end else begin
            foreach (words[i]) begin
                if (wr_log[i].addr !== D'(i) || wr_log[i].data !== words[i]) begin
                    n_bad++;
                    $display("FAIL %s_write_log[%0d]: addr=%0d data=%h required %0d %h",
                             name, i, wr_log[i].addr, wr_log[i].data, i, words[i]);
                    break;
                end
            end
        end
        // Status must hold while idle in RUN/ERR.
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.cpu_hold !== !ok || bus.words_loaded !== D'(words.size()) || bus.wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_hold_status: hold=%b cnt=%0d wr_en=%b required %b %0d 0",
                     name, bus.cpu_hold, bus.words_loaded, bus.wr_en, !ok, words.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.cpu_hold !== 1'b1 || bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0 ||
            bus.wr_addr !== '0 || bus.wr_data !== '0 || bus.load_ok !== 1'b0 ||
            bus.load_err !== 1'b0 || bus.words_loaded !== '0) begin
            n_bad++;
            $display("FAIL reset_state: hold=%b rdy=%b wr=%b addr=%0d data=%h ok=%b err=%b cnt=%0d required 1 0 0 0 0 0 0 0",
                     bus.cpu_hold, bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
                     bus.load_ok, bus.load_err, bus.words_loaded);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.cpu_hold !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_idle: hold=%b rdy=%b required 1 0", bus.cpu_hold, bus.in_ready);
        end
    endtask

    task automatic test_basic();
        do_load("basic", '{9'h101, 9'h0F0, 9'h003}, 9'h1F2, 1'b0);
    endtask

    task automatic test_bad_checksum();
        do_load("bad_csum", '{9'h001, 9'h002}, 9'h000, 1'b0);
    endtask

    task automatic test_zero_len();
        word_q_t none;
        none = {};
        do_load("zero_len", none, 9'h000, 1'b0);
    endtask

    task automatic test_backpressure();
        word_q_t w;
        w = {};
        repeat (4) w.push_back(W'($urandom));
        do_load("backpressure", w, model_csum(w), 1'b1);
    endtask

    task automatic test_start_during_load();
        logic [W-1:0] w0, w1, w2;
        w0 = 9'h055; w1 = 9'h1C3; w2 = 9'h00F;
        wr_log.delete();
        do_start(D'(3));
        send(w0, 1'b1, D'(0), 1'b0);
        bus.start = 1'b1;
        bus.len   = D'(7);
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.words_loaded !== D'(1)) begin
            n_bad++;
            $display("FAIL start_ignored: rdy=%b hold=%b cnt=%0d required 1 1 1",
                     bus.in_ready, bus.cpu_hold, bus.words_loaded);
        end
        send(w1, 1'b1, D'(1), 1'b0);
        send(w2, 1'b1, D'(2), 1'b0);
        send(w0 ^ w1 ^ w2, 1'b0, '0, 1'b0);
        n_cmp++;
        if (bus.load_ok !== 1'b1 || bus.words_loaded !== D'(3) || wr_log.size() != 3) begin
            n_bad++;
            $display("FAIL start_ignored_result: ok=%b cnt=%0d writes=%0d required 1 3 3",
                     bus.load_ok, bus.words_loaded, wr_log.size());
        end
    endtask

    task automatic test_reset_mid_load();
        wr_log.delete();
        do_start(D'(5));
        send(9'h111, 1'b1, D'(0), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 9'h122;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.wr_en !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.words_loaded !== '0 ||
            bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_load: wr_en=%b hold=%b cnt=%0d rdy=%b required 0 1 0 0",
                     bus.wr_en, bus.cpu_hold, bus.words_loaded, bus.in_ready);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (wr_log.size() != 1 || bus.cpu_hold !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_load_after: writes=%0d hold=%b rdy=%b required 1 1 0",
                     wr_log.size(), bus.cpu_hold, bus.in_ready);
        end
    endtask

    task automatic test_reload();
        do_load("pre_reload", '{9'h0AB}, 9'h0AB, 1'b0);
        n_cmp++;
        if (bus.cpu_hold !== 1'b0 || bus.load_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL reload_in_run: hold=%b ok=%b required 0 1", bus.cpu_hold, bus.load_ok);
        end
        do_load("reload", '{9'h1AA}, 9'h1AA, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            word_q_t w;
            logic [W-1:0] cs;
            int n;
            w = {};
            n = int'($urandom_range(0, 9));
            repeat (n) w.push_back(W'($urandom));
            cs = model_csum(w);
            if ($urandom_range(0, 9) < 3) cs = cs ^ W'($urandom_range(1, 511));
            do_load($sformatf("rand%0d", t), w, cs, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_max_len();
        word_q_t w;
        w = {};
        for (int i = 0; i < (1 << D) - 1; i++) w.push_back(W'($urandom));
        do_load("max_len", w, model_csum(w), 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_zero_len();
        test_backpressure();
        test_start_during_load();
        test_reset_mid_load();
        test_reload();
        test_random();
        test_max_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
